// File: rtl/switch_pkg.sv
// Shared switch definitions: default port/VOQ counts, VOQ index type and
// the scheduler FSM state encoding.
package switch_pkg;
  localparam int N_PORTS = 4;
  localparam int N_VOQ   = 4;

  typedef logic [$clog2(N_VOQ)-1:0] voq_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;
endpackage

// File: rtl/rr_first_nonempty.sv
// Combinational search for the first non-empty entry scanning start,
// start+1, ... modulo N (N need not be a power of two).
module rr_first_nonempty #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  empty,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW:0] cand;

  // Scan from the far end back toward start so the nearest hit wins.
  always_comb begin
    idx  = start;
    cand = '0;
    for (int k = N-1; k >= 0; k--) begin
      cand = {1'b0, start} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!empty[cand[IW-1:0]]) idx = cand[IW-1:0];
    end
  end

  assign found = ~&empty;
endmodule

// File: rtl/voq_rr_scheduler.sv
// Registered round-robin VOQ scheduler with rotating pointer, valid/ready
// grant handshake and optional per-VOQ burst of up to MAX_BURST grants.
module voq_rr_scheduler
  import switch_pkg::*;
#(
  parameter int N_VOQ     = switch_pkg::N_VOQ,
  parameter int MAX_BURST = 1,
  parameter int IDX_W     = $clog2(N_VOQ)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_VOQ-1:0] voq_empty,
  input  logic             sched_en,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_VOQ-1:0] grant_onehot,
  input  logic             grant_ready,
  output logic             all_empty
);
  localparam int               CNT_W = $clog2(MAX_BURST+1);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_VOQ-1);
  localparam logic [CNT_W-1:0] BURST = CNT_W'(MAX_BURST);

  sched_state_t     state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, last_idx, last_n, idx_n, search_idx;
  logic [CNT_W-1:0] burst_cnt, cnt_n, cnt_inc;
  logic             cont, cont_n, search_found;

  rr_first_nonempty #(.N(N_VOQ), .IW(IDX_W)) u_search (
    .empty (voq_empty),
    .start (ptr),
    .found (search_found),
    .idx   (search_idx)
  );

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    last_n  = last_idx;
    cnt_n   = burst_cnt;
    cont_n  = cont;
    idx_n   = grant_idx;
    cnt_inc = burst_cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        // search_found is exactly !all_empty
        if (sched_en && search_found) begin
          if (cont && !voq_empty[last_idx]) begin
            idx_n = last_idx;
          end else begin
            idx_n  = search_idx;
            cnt_n  = '0;
            cont_n = 1'b0;
          end
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (grant_ready) begin
          state_n = IDLE;
          last_n  = grant_idx;
          ptr_n   = (grant_idx == LAST) ? '0 : grant_idx + IDX_W'(1);
          if (cnt_inc < BURST) begin
            cnt_n  = cnt_inc;
            cont_n = 1'b1;
          end else begin
            cnt_n  = '0;
            cont_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      last_idx  <= '0;
      burst_cnt <= '0;
      cont      <= 1'b0;
      grant_idx <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      last_idx  <= last_n;
      burst_cnt <= cnt_n;
      cont      <= cont_n;
      grant_idx <= idx_n;
    end
  end

  // Valid comes straight from the state flop so async reset clears it at once.
  assign grant_valid  = (state == GRANT);
  assign grant_onehot = grant_valid ? (N_VOQ'(1) << grant_idx) : '0;
  assign all_empty    = &voq_empty;
endmodule

// File: tb/tb_voq_rr_scheduler.sv
// Directed bench for voq_rr_scheduler: three instances (4 VOQ round-robin,
// 4 VOQ burst-of-3, 3 VOQ round-robin) checked against a grant scoreboard.
module tb_voq_rr_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] ve0, ve1;
  logic [2:0] ve2;
  logic       sen0, sen1, sen2, rdy0, rdy1, rdy2;
  logic       gv0, gv1, gv2, ae0, ae1, ae2;
  logic [1:0] gi0, gi1, gi2;
  logic [3:0] oh0, oh1;
  logic [2:0] oh2;

  logic       gv_a [3];
  logic [1:0] gi_a [3];
  logic [3:0] oh_a [3];
  assign gv_a[0] = gv0;
  assign gv_a[1] = gv1;
  assign gv_a[2] = gv2;
  assign gi_a[0] = gi0;
  assign gi_a[1] = gi1;
  assign gi_a[2] = gi2;
  assign oh_a[0] = oh0;
  assign oh_a[1] = oh1;
  assign oh_a[2] = {1'b0, oh2};

  voq_rr_scheduler #(.N_VOQ(4), .MAX_BURST(1)) dut0 (
    .clk(clk), .reset_n(rst_n), .voq_empty(ve0), .sched_en(sen0),
    .grant_valid(gv0), .grant_idx(gi0), .grant_onehot(oh0),
    .grant_ready(rdy0), .all_empty(ae0));

  voq_rr_scheduler #(.N_VOQ(4), .MAX_BURST(3)) dut1 (
    .clk(clk), .reset_n(rst_n), .voq_empty(ve1), .sched_en(sen1),
    .grant_valid(gv1), .grant_idx(gi1), .grant_onehot(oh1),
    .grant_ready(rdy1), .all_empty(ae1));

  voq_rr_scheduler #(.N_VOQ(3), .MAX_BURST(1)) dut2 (
    .clk(clk), .reset_n(rst_n), .voq_empty(ve2), .sched_en(sen2),
    .grant_valid(gv2), .grant_idx(gi2), .grant_onehot(oh2),
    .grant_ready(rdy2), .all_empty(ae2));

  int n_cmp = 0;
  int n_bad = 0;
  int q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Wait up to budget falling edges for a grant on instance d, then compare
  // index and one-hot against the oldest scoreboard entry.
  task automatic expect_grant(input int d, input string tag, input int budget);
    int exp_i;
    bit seen;
    seen  = 1'b0;
    exp_i = (q.size() > 0) ? q.pop_front() : -1;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (gv_a[d] === 1'b1) seen = 1'b1;
    end
    chk({tag, "_vld"}, 8'(seen), 8'd1);
    if (seen) begin
      chk({tag, "_idx"}, 8'(gi_a[d]), 8'(exp_i));
      chk({tag, "_oh"}, 8'(oh_a[d]), 8'(4'b0001 << exp_i));
    end
  endtask

  initial begin
    ve0 = 4'b0000; ve1 = 4'b0000; ve2 = 3'b000;
    sen0 = 1'b1; sen1 = 1'b0; sen2 = 1'b0;
    rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;

    // Reset state, then first grant one cycle after release
    repeat (3) @(negedge clk);
    chk("rst_vld", 8'(gv0), 8'd0);
    chk("rst_oh", 8'(oh0), 8'd0);
    chk("rst_idx", 8'(gi0), 8'd0);
    rst_n = 1'b1;
    q.push_back(0);
    expect_grant(0, "t1", 1);

    // Stall: inputs wiggle, grant must hold
    for (int k = 0; k < 5; k++) begin
      ve0  = 4'(k * 5 + 3);
      sen0 = k[0];
      @(negedge clk);
      chk("t5_vld", 8'(gv0), 8'd1);
      chk("t5_idx", 8'(gi0), 8'd0);
    end
    ve0 = 4'b0000; sen0 = 1'b1; rdy0 = 1'b1;
    @(negedge clk);
    chk("t5_hs", 8'(gv0), 8'd0);

    // Round-robin fairness
    for (int k = 1; k <= 4; k++) begin
      q.push_back(k % 4);
      expect_grant(0, "t2", 2);
    end

    // Skip and wrap
    ve0 = 4'b1011; q.push_back(2); expect_grant(0, "t3a", 2);
    ve0 = 4'b1011; q.push_back(2); expect_grant(0, "t3b", 2);
    ve0 = 4'b0111; q.push_back(3); expect_grant(0, "t3c", 2);
    ve0 = 4'b0000; q.push_back(0); expect_grant(0, "t3d", 2);
    ve0 = 4'b1111;
    repeat (4) begin
      @(negedge clk);
      chk("t3_empty_vld", 8'(gv0), 8'd0);
    end
    chk("t3_all_empty", 8'(ae0), 8'd1);
    sen0 = 1'b0;

    // Burst of 3
    sen1 = 1'b1; rdy1 = 1'b1; ve1 = 4'b1101;
    q.push_back(1); expect_grant(1, "t4a", 2);
    ve1 = 4'b0000;
    q.push_back(1); expect_grant(1, "t4b", 2);
    q.push_back(1); expect_grant(1, "t4c", 2);
    q.push_back(2); expect_grant(1, "t4d", 2);
    // Held VOQ empties: resume search from the pointer
    ve1 = 4'b1101; q.push_back(1); expect_grant(1, "t4e", 2);
    ve1 = 4'b0000; q.push_back(1); expect_grant(1, "t4f", 2);
    ve1 = 4'b0010; q.push_back(2); expect_grant(1, "t4g", 2);
    ve1 = 4'b0000; q.push_back(2); expect_grant(1, "t4h", 2);
    // Disable mid-burst keeps the burst alive
    sen1 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t4_dis_vld", 8'(gv1), 8'd0);
    end
    sen1 = 1'b1;
    q.push_back(2); expect_grant(1, "t4i", 2);
    q.push_back(3); expect_grant(1, "t4j", 2);
    sen1 = 1'b0;

    // Three VOQs
    sen2 = 1'b1; rdy2 = 1'b1; ve2 = 3'b000;
    for (int k = 0; k < 4; k++) begin
      q.push_back(k % 3);
      expect_grant(2, "t6", 2);
    end
    ve2 = 3'b111;
    repeat (4) begin
      @(negedge clk);
      chk("t6_empty_vld", 8'(gv2), 8'd0);
    end
    chk("t6_all_empty", 8'(ae2), 8'd1);

    // Async reset drops a pending grant immediately
    ve2 = 3'b000; rdy2 = 1'b0;
    q.push_back(1); expect_grant(2, "t7", 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_rst_vld", 8'(gv2), 8'd0);
    chk("t7_rst_oh", 8'(oh_a[2]), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/voq_rr_scheduler.md
Name: voq_rr_scheduler

Overview:
- Registered round-robin scheduler choosing which VOQ of one ingress port dequeues next.
- Sits between the VOQ bank's empty flags and the ingress dequeue/crossbar-request logic.
- Generalises the combinational "first non-empty VOQ from a start index" search:
  - parametrised VOQ count;
  - self-maintained rotating priority pointer;
  - valid/ready grant handshake;
  - optional burst mode that keeps one VOQ granted for up to MAX_BURST packets.

Parameters:
- N_VOQ, default 4: number of VOQs; must be ≥2; need not be a power of two.
- MAX_BURST, default 1: maximum consecutive grants to one VOQ before the pointer moves on; must be ≥1; 1 = pure round-robin.
- IDX_W, default $clog2(N_VOQ): VOQ index width. Derived; do not override.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- voq_empty  in  N_VOQ  bit i = 1 when VOQ i is empty.
- sched_en  in  1  enables issuing new grants.
- grant_valid  out  1  a grant is presented.
- grant_idx  out  IDX_W  granted VOQ index.
- grant_onehot  out  N_VOQ  one-hot decode of grant_idx; all zeros when grant_valid=0.
- grant_ready  in  1  downstream accepts the grant (one packet dequeued).
- all_empty  out  1  combinational &voq_empty.

Behaviour:
- Reset (async assert, sync-safe deassert to first clk edge) clears:
  - grant_valid=0, grant_idx=0, grant_onehot=0;
  - ptr=0, last_idx=0, burst_cnt=0, cont=0; FSM to IDLE.
- all_empty does not depend on reset.
- FSM states IDLE, GRANT.
- IDLE, each cycle:
  - If sched_en=0 or all_empty=1: stay IDLE.
  - Else if cont=1 and voq_empty[last_idx]=0: grant_idx<=last_idx (burst continues).
  - Else: grant_idx<=first i scanning ptr, ptr+1, … mod N_VOQ with voq_empty[i]=0; clear burst_cnt<=0 and cont<=0.
  - Then grant_valid<=1 and go to GRANT.
  - Latency: grant_valid rises the cycle after a qualifying IDLE cycle.
- GRANT:
  - grant_valid=1. grant_idx and grant_onehot are stable until the handshake.
  - voq_empty and sched_en are ignored; a grant is never withdrawn.
- Handshake (grant_valid & grant_ready) at edge:
  - grant_valid<=0; go to IDLE.
  - last_idx<=grant_idx.
  - ptr<=(grant_idx+1) mod N_VOQ on every handshake.
  - n = burst_cnt+1. If n<MAX_BURST: burst_cnt<=n, cont<=1. Else: burst_cnt<=0, cont<=0.
- Throughput: at most one grant per 2 cycles. The IDLE bubble lets voq_empty reflect the dequeue.
- Burst ends early if the held VOQ is empty in IDLE; the search then starts at last_idx+1 (already in ptr).
- MAX_BURST=1: cont is never set, giving strict round-robin.
- Wrap: pointer/index arithmetic is explicit mod N_VOQ, not bit truncation. Required for N_VOQ=3, 5, ….
- burst_cnt width: $clog2(MAX_BURST+1); no overflow possible.
- sched_en falling while cont=1 keeps cont. The burst resumes when enabled if the VOQ is still non-empty.
- reset_n asserted mid-GRANT drops grant_valid immediately (asynchronously).

Decomposition:
- Shared package switch_pkg holds:
  - N_PORTS / N_VOQ default;
  - voq_idx_t typedef;
  - the FSM state enum type sched_state_t.
- One natural sub-module, rr_first_nonempty:
  - parameter N;
  - inputs empty[N], start idx;
  - outputs found, idx;
  - combinational mod-N priority search;
  - instantiated once for the IDLE search.

Test Plan:
1. Reset, N_VOQ=4, MAX_BURST=1: hold reset_n=0 with voq_empty=4'b0000 → grant_valid=0, grant_onehot=0. Release with sched_en=1 → grant_idx=0 one cycle later.
2. Round-robin fairness, N_VOQ=4, MAX_BURST=1: voq_empty=0000, grant_ready=1 always → grants 0,1,2,3,0 on alternate cycles.
3. Skip and wrap: ptr=3, voq_empty=4'b1011 (only VOQ 2 non-empty) → grant_idx=2, ptr becomes 3. Then voq_empty=4'b0111 → grant_idx=3, ptr wraps to 0.
4. Burst, MAX_BURST=3: VOQ1 non-empty throughout → 3 consecutive grants to 1, then 2. Make VOQ1 empty after its 2nd grant → next grant goes to 2, not 1.
5. Stall/stability: grant_ready=0 for 5 cycles while voq_empty toggles and sched_en drops → grant_valid and grant_idx held constant; single handshake when ready=1.
6. Non-power-of-2, N_VOQ=3: all non-empty → grants 0,1,2,0; grant_idx never 3. all_empty=1 with voq_empty=3'b111 → no grant issued.
